// File: rtl/sprite_rom_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : sprite_rom_loader_if                                    |
// | Desc   : Overlay read port and byte-stream load port of the      |
// |          sprite pixel memory.                                    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface sprite_rom_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] pixel_addr;
  logic [DATA_W-1:0] rgb_pixel;
  logic              vblnk;
  logic              load_sof;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              load_done;
  logic              busy;

  // Overlay stage / host side
  modport master (
    output pixel_addr, vblnk, load_sof, load_valid, load_data,
    input  rgb_pixel, load_ready, load_done, busy
  );

  // Pixel memory side
  modport slave (
    input  pixel_addr, vblnk, load_sof, load_valid, load_data,
    output rgb_pixel, load_ready, load_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : sprite_rom_loader                                       |
// | Desc   : 64x64 sprite pixel memory. Registered 1-cycle read for  |
// |          the overlay; image loads from a byte stream packed as   |
// |          {hi[3:0], lo[7:0]} per pixel.                           |
// |          Optional macro SPRITE_DBUF_EN: two banks, the loaded    |
// |          bank becomes visible on the next vblnk rising edge.     |
// |          Without it a single bank is written in place.           |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module sprite_rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  wire logic          clk65MHz,
  input  wire logic          rst,
  sprite_rom_loader_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef SPRITE_DBUF_EN
  localparam int IDX_W = ADDR_W + 1;
`else
  localparam int IDX_W = ADDR_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HI   = 2'd1,
    WAIT_LO   = 2'd2,
    SWAP_PEND = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] waddr, waddr_d;
  logic [3:0]        hi_reg, hi_d;
  logic              load_done_q, done_d;
  logic [DATA_W-1:0] rgb_q;
  logic              accept;
  logic              we;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [2**IDX_W];

`ifdef SPRITE_DBUF_EN
  logic front_sel;
  logic vblnk_q;
  logic swap;
  // Reads come from the displayed bank, writes go to the hidden one
  assign rd_idx = {front_sel, bus.pixel_addr};
  assign wr_idx = {~front_sel, waddr};
`else
  logic unused_vblnk;
  assign unused_vblnk = bus.vblnk;
  assign rd_idx = bus.pixel_addr;
  assign wr_idx = waddr;
`endif

  assign bus.load_ready = (state != SWAP_PEND);
  assign bus.busy       = (state != IDLE);
  assign bus.load_done  = load_done_q;
  assign bus.rgb_pixel  = rgb_q;
  assign accept         = bus.load_valid && bus.load_ready;
  // hi[7:4] is dropped: only the red nibble travels in the first byte
  assign wdata          = DATA_W'({hi_reg, bus.load_data});

  // Next-state and write-enable decode; load_sof restarts from any state
  always_comb begin
    state_d = state;
    waddr_d = waddr;
    hi_d    = hi_reg;
    we      = 1'b0;
    done_d  = 1'b0;
`ifdef SPRITE_DBUF_EN
    swap    = 1'b0;
`endif
    if (bus.load_sof) begin
      waddr_d = '0;
      state_d = WAIT_HI;
      // A byte arriving with a restart is hi of pixel 0; in IDLE it is dropped
      if (accept && state != IDLE) begin
        hi_d    = bus.load_data[3:0];
        state_d = WAIT_LO;
      end
    end else begin
      case (state)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_HI: begin
          if (accept) begin
            hi_d    = bus.load_data[3:0];
            state_d = WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (accept) begin
            we = 1'b1;
            if (waddr == LAST_ADDR) begin
`ifdef SPRITE_DBUF_EN
              state_d = SWAP_PEND;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              waddr_d = waddr + 1'b1;
              state_d = WAIT_HI;
            end
          end
        end
        SWAP_PEND: begin
`ifdef SPRITE_DBUF_EN
          // Edge-detect so a blank already in progress is not used
          if (bus.vblnk && !vblnk_q) begin
            swap    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and load-address registers
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state       <= IDLE;
      waddr       <= '0;
      hi_reg      <= '0;
      load_done_q <= 1'b0;
    end else begin
      state       <= state_d;
      waddr       <= waddr_d;
      hi_reg      <= hi_d;
      load_done_q <= done_d;
    end
  end

`ifdef SPRITE_DBUF_EN
  // Bank select toggles only on an accepted vblank edge
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      front_sel <= 1'b0;
      vblnk_q   <= 1'b0;
    end else begin
      vblnk_q <= bus.vblnk;
      if (swap) front_sel <= ~front_sel;
    end
  end
`endif

  // Pixel memory write port; contents survive reset
  always_ff @(posedge clk65MHz) begin
    if (we && !rst) mem[wr_idx] <= wdata;
  end

  // Registered read, old data on a same-address write
  always_ff @(posedge clk65MHz) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= mem[rd_idx];
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_sprite_rom_loader                                    |
// | Desc   : Randomised bench for sprite_rom_loader with a pixel-    |
// |          array reference model and a queue-based monitor.        |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sprite_rom_loader;

  localparam int DEPTH  = 4096;
  localparam int NBYTES = 2 * DEPTH;
`ifdef SPRITE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_SWAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_rom_loader_if #(.ADDR_W(12), .DATA_W(12)) bus ();

  sprite_rom_loader #(.ADDR_W(12), .DATA_W(12)) dut (
    .clk65MHz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    int          cyc;
    logic [11:0] rgb;
    bit          rgb_known;
    bit          ready;
    bit          busy;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   total    = 0;
  int   bad      = 0;
  bit   vb_level = 1'b0;

  // Reference: displayed image per bank, plus load progress in bytes
  logic [11:0] mbank  [2][DEPTH];
  bit          mknown [2][DEPTH];
  int          mfront = 0;
  int          mmode  = M_IDLE;
  int          mcnt   = 0;
  logic [3:0]  mhi    = 4'h0;
  bit          mvprev = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at edge %0d", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic logic [11:0] pix(input int kind, input int i);
    case (kind)
      0:       return 12'(i * 37 + 11);
      1:       return 12'(i * 53 + 5);
      2:       return {4'hA, 8'(i)};
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input int kind, input int j);
    logic [11:0] w;
    logic [3:0]  nib;
    w = pix(kind, j / 2);
    if (kind == 2)      nib = 4'hF;
    else if (kind == 3) nib = 4'h0;
    else                nib = 4'($urandom);
    if (j % 2 == 0) return {nib, w[11:8]};
    return w[7:0];
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the edge
  task automatic step(input bit r, input bit sof, input bit valid, input logic [7:0] data,
                      input bit vb, input logic [11:0] addr, output bit acc);
    exp_t e;
    int   brd;
    int   bwr;
    @(posedge clk); #1;
    rst            = r;
    bus.load_sof   = sof;
    bus.load_valid = valid;
    bus.load_data  = data;
    bus.vblnk      = vb;
    bus.pixel_addr = addr;
    brd    = DBUF ? mfront : 0;
    bwr    = DBUF ? 1 - mfront : 0;
    e.cyc  = edge_cnt + 1;
    e.done = 1'b0;
    acc    = 1'b0;
    if (r) begin
      e.rgb       = 12'h000;
      e.rgb_known = 1'b1;
      mfront      = 0;
      mmode       = M_IDLE;
      mvprev      = 1'b0;
    end else begin
      e.rgb       = mbank[brd][addr];
      e.rgb_known = mknown[brd][addr];
      acc         = valid && (mmode != M_SWAP);
      if (sof) begin
        mcnt = 0;
        if (acc && mmode != M_IDLE) begin
          mhi  = data[3:0];
          mcnt = 1;
        end
        mmode = M_LOAD;
      end else if (mmode == M_LOAD && acc) begin
        if (mcnt % 2 == 0) begin
          mhi = data[3:0];
        end else begin
          mbank[bwr][mcnt / 2]  = {mhi, data};
          mknown[bwr][mcnt / 2] = 1'b1;
        end
        if (mcnt == NBYTES - 1) begin
          if (DBUF) mmode = M_SWAP;
          else begin
            mmode  = M_IDLE;
            e.done = 1'b1;
          end
        end
        mcnt++;
      end else if (mmode == M_SWAP && vb && !mvprev) begin
        mfront = 1 - mfront;
        e.done = 1'b1;
        mmode  = M_IDLE;
      end
      mvprev = vb;
    end
    e.ready = (mmode != M_SWAP);
    e.busy  = (mmode != M_IDLE);
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input bit valid);
    bit acc;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, valid, 8'($urandom), vb_level, 12'($urandom), acc);
  endtask

  task automatic sof_only();
    bit acc;
    step(1'b0, 1'b1, 1'b0, 8'h00, vb_level, 12'($urandom), acc);
  endtask

  // Send bytes first..first+n-1 of an image, valid asserted with probability prob%
  task automatic load_bytes(input int kind, input int first, input int n, input int prob);
    bit acc;
    bit v;
    int tries;
    for (int j = first; j < first + n; j++) begin
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 1000) begin
        v = ($urandom_range(99) < prob);
        step(1'b0, 1'b0, v, v ? byte_of(kind, j) : 8'($urandom), vb_level, 12'($urandom), acc);
        tries++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL byte_accept: got none want accept of byte %0d", j);
      end
    end
  endtask

  task automatic vblank_pulse(input bit valid);
    vb_level = 1'b0; idle_cycles(3, valid);
    vb_level = 1'b1; idle_cycles(6, valid);
    vb_level = 1'b0; idle_cycles(2, valid);
  endtask

  task automatic sweep();
    bit acc;
    for (int a = 0; a < DEPTH; a++)
      step(1'b0, 1'b0, 1'b0, 8'h00, vb_level, 12'(a), acc);
  endtask

  task automatic read_check(input string name, input logic [11:0] addr, input logic [11:0] want);
    bit acc;
    step(1'b0, 1'b0, 1'b0, 8'h00, vb_level, addr, acc);
    step(1'b0, 1'b0, 1'b0, 8'h00, vb_level, 12'($urandom), acc);
    chk(name, bus.rgb_pixel, want);
  endtask

  // Monitor: compare every queued expectation at its own edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
        e = sb.pop_front();
        if (e.cyc == edge_cnt) begin
          if (e.rgb_known) chk("rgb_pixel", bus.rgb_pixel, e.rgb);
          chk("load_ready", 12'(bus.load_ready), 12'(e.ready));
          chk("busy", 12'(bus.busy), 12'(e.busy));
          chk("load_done", 12'(bus.load_done), 12'(e.done));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit acc;
    bus.load_sof   = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.vblnk      = 1'b0;
    bus.pixel_addr = 12'h000;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 12'h000, acc);

    // Two preload images so bank 0 holds known data
    sof_only(); load_bytes(0, 0, NBYTES, 100); vblank_pulse(1'b0);
    sof_only(); load_bytes(1, 0, NBYTES, 100); vblank_pulse(1'b0);

    // Reset in the middle of a load
    sof_only(); load_bytes(0, 0, 101, 100);
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 12'h000, acc);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 12'h000, acc);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h000, acc);
    chk("reset_rgb", bus.rgb_pixel, 12'h000);
    chk("reset_ready", 12'(bus.load_ready), 12'h001);
    chk("reset_busy", 12'(bus.busy), 12'h000);
    chk("reset_done", 12'(bus.load_done), 12'h000);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h041, acc);
    idle_cycles(2, 1'b0);

    // Full gap-free load, then backpressure while the swap is pending
    vb_level = 1'b0;
    sof_only(); load_bytes(2, 0, NBYTES, 100);
    idle_cycles(20, 1'b1);
    vblank_pulse(1'b1);
    read_check("addr_005_after_full", 12'h005, 12'hA05);

    // Gappy load of the same image, vblnk already high at the last byte
    sof_only(); load_bytes(2, 0, NBYTES - 1, 60);
    vb_level = 1'b1; idle_cycles(2, 1'b0);
    load_bytes(2, NBYTES - 1, 1, 60);
    idle_cycles(8, 1'b0);
    vb_level = 1'b0; idle_cycles(3, 1'b0);
    vb_level = 1'b1; idle_cycles(3, 1'b0);
    vb_level = 1'b0; idle_cycles(2, 1'b0);
    sweep();

    // Abort after 1000 bytes; restart carries hi of pixel 0 in the same cycle
    sof_only(); load_bytes(0, 0, 1000, 80);
    step(1'b0, 1'b1, 1'b1, 8'h0F, vb_level, 12'($urandom), acc);
    load_bytes(3, 1, NBYTES - 1, 90);
    vblank_pulse(1'b0);
    read_check("addr_123_after_abort", 12'h123, 12'hFFF);
    sweep();

    // Pixel 0 = 0x321, then a same-cycle read/write on pixel 1
    sof_only();
    step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 12'h000, acc);
    step(1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 12'h000, acc);
    step(1'b0, 1'b0, 1'b1, 8'hA7, 1'b0, 12'h000, acc);
    step(1'b0, 1'b0, 1'b1, 8'h9C, 1'b0, 12'h001, acc);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 12'h001, acc);
    idle_cycles(4, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 12'h000, acc);
    idle_cycles(4, 1'b0);

    repeat (4) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_rom_loader.md
Name: sprite_rom_loader

Overview:
- Pixel-memory responder for the rectangle/sprite overlay stage.
- Answers the overlay's 12-bit pixel_addr {y[5:0], x[5:0]} with a registered 12-bit RGB word.
- Loads new 64x64 sprite images from an 8-bit byte stream (UART/host side) into a back bank.
- Swaps banks only during vertical blanking, so a frame never shows a half-loaded image.

Parameters:
- ADDR_W, 12, read/write address width; depth = 2**ADDR_W pixels per bank.
- DATA_W, 12, pixel width {R[3:0], G[3:0], B[3:0]}.

Ports:
- clk65MHz  in  1  pixel clock.
- rst  in  1  reset.
- pixel_addr  in  ADDR_W  read address from the overlay stage, {y[5:0], x[5:0]}.
- rgb_pixel  out  DATA_W  pixel at pixel_addr, registered.
- vblnk  in  1  vertical blank from the VGA timing stream.
- load_sof  in  1  start-of-image pulse.
- load_valid  in  1  byte valid.
- load_data  in  8  byte payload.
- load_ready  out  1  byte accept.
- load_done  out  1  one-cycle pulse when a new image becomes visible.
- busy  out  1  high in WAIT_HI, WAIT_LO and SWAP_PEND.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk65MHz.
- Reset values:
  - rgb_pixel=0, load_done=0, busy=0, load_ready=1.
  - front_sel=0, waddr=0, state=IDLE, vblnk_q=0.
  - Memory contents are not cleared.
- Read path, latency exactly 1 cycle: rgb_pixel <= mem[front_sel][pixel_addr] every cycle, regardless of load state.
- Handshake:
  - A byte is accepted when load_valid && load_ready.
  - load_ready=1 in IDLE, WAIT_HI and WAIT_LO; load_ready=0 in SWAP_PEND.
- Pixel packing:
  - First byte is hi; only hi[3:0] (R) is used, hi[7:4] is ignored.
  - Second byte is {G, B}.
  - Written word = {hi[3:0], lo[7:0]}.
- IDLE: accepted bytes are discarded. load_sof -> waddr=0, WAIT_HI.
- WAIT_HI: accepted byte is stored in hi_reg, then WAIT_LO.
- WAIT_LO:
  - On an accepted byte, write mem[~front_sel][waddr] = {hi_reg[3:0], byte}.
  - If waddr == 2**ADDR_W-1, go to SWAP_PEND; otherwise waddr++ and go to WAIT_HI.
- SWAP_PEND:
  - Wait for a vblnk rising edge (vblnk && !vblnk_q).
  - If vblnk is already high on entry, wait for the next rising edge.
  - On the edge: front_sel toggles, load_done=1 for one cycle, then IDLE.
  - The first read using the new bank is in the cycle after the toggle.
- load_sof while in WAIT_HI, WAIT_LO or SWAP_PEND:
  - Aborts the current load and cancels any pending swap.
  - waddr=0, go to WAIT_HI.
  - A byte accepted in the same cycle as load_sof is treated as hi of pixel 0.
- waddr is ADDR_W bits wide and never wraps; the last pixel always forces SWAP_PEND.
- Reads and writes target different banks, so there are no collisions.
- Reset mid-load: the state machine returns to IDLE and front_sel returns to 0. The partially written bank is left as-is.

Optional Feature:
- Macro: SPRITE_DBUF_EN.
- Defined: two banks, SWAP_PEND state, vblank-synchronised swap, as described above.
- Not defined:
  - Single bank; writes go to the displayed bank immediately and tearing is allowed.
  - After the last pixel write: state goes to IDLE, load_done pulses in the next cycle, SWAP_PEND is never entered.
  - A read and write to the same address in the same cycle returns the old data (read-first).
  - front_sel does not exist.

Test Plan:
- Reset, then pixel_addr=0x000 then 0x041 -> rgb_pixel equals the preloaded bank-0 words exactly 1 cycle after each address; load_ready=1, busy=0.
- Full load: load_sof, then 8192 bytes alternating 0xFA and (pixel index & 0xFF) with vblnk=0 throughout -> load_ready=0 after the last byte, no load_done, display unchanged; then raise vblnk -> load_done pulses once, and the next read of addr 0x005 returns 0xA05.
- Backpressure: hold load_valid=1 continuously while in SWAP_PEND -> no byte is consumed until the swap. Also toggle load_valid randomly during a load -> image is identical to the gap-free load.
- Abort: load_sof after 1000 bytes, then a full 8192-byte load of 0x0F,0xFF -> after the swap every address reads 0xFFF.
- vblnk already high at SWAP_PEND entry -> swap waits for a 0->1 transition; load_done is low during the current blank.
- Without SPRITE_DBUF_EN: load_sof, then write hi=0x03, lo=0x21 to pixel 0 -> the read of addr 0 returns 0x321 without waiting for vblnk. A same-cycle read/write to one address returns the old value.
